// File: rtl/qsys_p01_key_input.sv
// Push-button PIO with Avalon-MM register map, falling-edge capture and level irq.
// Optional per-bit debounce is built when KEY_INPUT_DEBOUNCE_EN is defined.
module qsys_p01_key_input #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_statePrev;
    logic [WIDTH-1:0] r_irqMask;
    logic [WIDTH-1:0] r_edgeCapture;

    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_clearMask;
    logic             w_write;
    logic             w_unusedBits;

    // Released buttons read as 1, so every stage resets to all-ones to avoid a false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef KEY_INPUT_DEBOUNCE_EN
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] r_dbCnt [WIDTH];

    // A bit only moves once its synchronized level has disagreed for DB_CYCLES cycles in a row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_state[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == CNT_LAST) begin
                    r_state[i] <= r_sync2[i];
                    r_dbCnt[i] <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= '1;
        end else begin
            r_state <= r_sync2;
        end
    end
`endif

    assign w_fall      = r_statePrev & ~r_state;
    assign w_write     = chipselect & ~write_n;
    assign w_clearMask = (w_write && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

    // A new edge is ORed in after the clear, so it survives a simultaneous clear-write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_statePrev   <= '1;
            r_edgeCapture <= '0;
            r_irqMask     <= '0;
        end else begin
            r_statePrev   <= r_state;
            r_edgeCapture <= (r_edgeCapture & ~w_clearMask) | w_fall;
            if (w_write && (address == 2'd1)) begin
                r_irqMask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(r_edgeCapture & r_irqMask);

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = r_state;
            2'd1:    readdata[WIDTH-1:0] = r_irqMask;
            2'd3:    readdata[WIDTH-1:0] = r_edgeCapture;
            default: readdata = '0;
        endcase
    end

    // Upper write-data bits and DB_CYCLES (in the plain build) have no function here.
    assign w_unusedBits = (^writedata) ^ (DB_CYCLES != 0);

endmodule

// File: doc/qsys_p01_key_input.md
QSYS_P01_KEY_INPUT -- requirements
Module: qsys_p01_key_input

Interface
REQ-001 Parameter WIDTH, default 4, number of input pins.
REQ-002 Parameter DB_CYCLES, default 50000, consecutive stable cycles required to accept a new pin level (debounce build only).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  2  Avalon-MM word address.
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 writedata  input  32  Avalon-MM write data.
REQ-009 readdata  output  32  Avalon-MM read data, zero wait states.
REQ-010 in_port  input  WIDTH  asynchronous push-button pins; pressed = 0.
REQ-011 irq  output  1  level interrupt request, active-high.

Function
REQ-012 in_port SHALL pass through a 2-flop synchronizer; sync output is the synchronized level.
REQ-013 Stable level "state" SHALL equal the sync output delayed one cycle (no debounce) or the debounced level (REQ-014).
REQ-014 Debounce per bit: counter clears when sync == state; increments while sync != state; on reaching DB_CYCLES-1, state takes sync and counter clears next cycle.
REQ-015 Falling edge on bit i SHALL be detected when state[i] goes 1->0, and SHALL set edgecapture[i] on the following clock.
REQ-016 Register map, addr 0: read = {zeros, state}; writes ignored.
REQ-017 Addr 1: irqmask, RW, low WIDTH bits of writedata.
REQ-018 Addr 2: reads 0; writes ignored.
REQ-019 Addr 3: edgecapture, read; write clears each bit i where writedata[i] = 1 (write-1-to-clear).
REQ-020 Write occurs when chipselect && !write_n; readdata is combinational from address; bits [31:WIDTH] always 0.
REQ-021 irq SHALL be |(edgecapture & irqmask), driven from registered values only.
REQ-022 Same cycle, same bit, clear-write and new edge: set wins; edgecapture bit stays 1.
REQ-023 Edge on a masked bit SHALL still set edgecapture; irq asserts immediately when the mask bit is later set.
REQ-024 A bounce shorter than DB_CYCLES SHALL neither change state nor set edgecapture.

Reset
REQ-025 On reset_n = 0, synchronizer flops and state SHALL go to all-ones (released), with no edge generated on reset release.
REQ-026 On reset, irqmask, edgecapture and debounce counters SHALL go to 0; irq SHALL go to 0.
REQ-027 Reset asserted mid-debounce SHALL discard the count; counting restarts from 0 after release.

Configuration
REQ-028 With KEY_INPUT_DEBOUNCE_EN defined, the REQ-014 counters SHALL be built and DB_CYCLES SHALL apply.
REQ-029 Without KEY_INPUT_DEBOUNCE_EN, no counters SHALL exist, DB_CYCLES SHALL be ignored, and state SHALL follow sync with one cycle delay.
REQ-030 The register map and irq behaviour SHALL be identical in both builds.

Verification (WIDTH=4, DB_CYCLES=8)
REQ-031 Reset, in_port=4'hF -> addr0 reads 0xF, addr1/addr3 read 0, irq=0; no edge after reset release.
REQ-032 Debounce build, drive in_port[0]=0 held 20 cycles -> addr0 reads 0xE, 2+8 cycles after change (±1); addr3 reads 0x1; irq=0 while mask=0.
REQ-033 Write addr1=0x1 with edgecapture=0x1 -> irq=1 next cycle; write addr3=0x1 -> edgecapture=0, irq=0 next cycle.
REQ-034 Debounce build, pulse in_port[2] low for 5 cycles -> addr0 stays 0xF, edgecapture stays 0.
REQ-035 Clear-write of bit 1 in the same cycle that bit 1's edge sets -> edgecapture[1] reads 1 afterwards.
REQ-036 Non-debounce build, in_port[3] falls -> addr0 reads 0x7 within 3 cycles; edgecapture[3]=1 one cycle later.
